// File: rtl/sample_deserializer.sv
// Collects four W-bit samples into lanes 0..3 and presents them as one 4*W-bit frame.
// Optional feature: define DESER_SUM_EN to add the registered out_sum frame-sum port.
module sample_deserializer #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           flush,
    input  logic [W-1:0]   in_data,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [4*W-1:0] out_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [1:0]     lane_sel,
    output logic           state_dbg
`ifdef DESER_SUM_EN
    ,
    output logic [W+1:0]   out_sum
`endif
);

    // Handshakes: a word moves when in_valid && in_ready, a frame moves when
    // out_valid && out_ready; in_ready is combinational from state, out_ready and flush.
    typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [1:0]          lane_sel_q, lane_sel_d;
    logic [3:0][W-1:0]   lanes_q, lanes_d;
    logic                in_acc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= FILL;
            lane_sel_q <= 2'd0;
            lanes_q    <= '0;
        end else begin
            state_q    <= state_d;
            lane_sel_q <= lane_sel_d;
            lanes_q    <= lanes_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        lane_sel_d = lane_sel_q;
        lanes_d    = lanes_q;
        if (flush) begin
            state_d    = FILL;
            lane_sel_d = 2'd0;
        end else begin
            case (state_q)
                FILL: begin
                    if (in_acc) begin
                        lanes_d[lane_sel_q] = in_data;
                        if (lane_sel_q == 2'd3) begin
                            state_d    = HOLD;
                            lane_sel_d = 2'd0;
                        end else begin
                            lane_sel_d = lane_sel_q + 2'd1;
                        end
                    end
                end
                HOLD: begin
                    // Frame leaves; a lane-0 word may enter on the same edge.
                    if (out_ready) begin
                        state_d = FILL;
                        if (in_acc) begin
                            lanes_d[0] = in_data;
                            lane_sel_d = 2'd1;
                        end
                    end
                end
                default: state_d = FILL;
            endcase
        end
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        if (!flush) begin
            in_ready = (state_q == FILL) ? 1'b1 : out_ready;
        end
        if (state_q == HOLD) begin
            out_valid = 1'b1;
        end
    end

    assign in_acc    = in_valid && in_ready;
    assign out_data  = lanes_q;
    assign lane_sel  = lane_sel_q;
    assign state_dbg = state_q;

`ifdef DESER_SUM_EN
    logic [W+1:0] acc_q, acc_d;
    logic [W+1:0] sum_q, sum_d;
    logic [W+1:0] word_ext;

    assign word_ext = {2'b00, in_data};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
            sum_q <= '0;
        end else begin
            acc_q <= acc_d;
            sum_q <= sum_d;
        end
    end

    // Every accepted word lands in lane lane_sel_q, including the pass-through case.
    always_comb begin
        acc_d = acc_q;
        sum_d = sum_q;
        if (in_acc) begin
            if (lane_sel_q == 2'd0) begin
                acc_d = word_ext;
            end else begin
                acc_d = acc_q + word_ext;
            end
            if (state_q == FILL && lane_sel_q == 2'd3) begin
                sum_d = acc_q + word_ext;
            end
        end
    end

    assign out_sum = sum_q;
`endif

endmodule
